// File: rtl/trigger_clk_phase_ctrl_pkg.sv
// trigger_clk_phase_ctrl_pkg: shared state encoding and defaults for the trigger-clock phase sequencer
package trigger_clk_phase_ctrl_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    STEP      = 3'd2,
    WAIT_DONE = 3'd3,
    ERROR     = 3'd4
  } state_t;
  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/trigger_clk_phase_ctrl_sync.sv
// trigger_clk_phase_ctrl_sync: two-flop synchronizer cell
module trigger_clk_phase_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {meta, q} <= 2'b00;
    else     {meta, q} <= {d, meta};
endmodule

// File: rtl/trigger_clk_phase_ctrl.sv
// trigger_clk_phase_ctrl: steps the trigger-clock MMCM phase one PSEN at a time toward a signed target
module trigger_clk_phase_ctrl
  import trigger_clk_phase_ctrl_pkg::*;
#(
  parameter int pPHASE_WIDTH = 16,
  parameter int pTIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                    usb_clk,
  input  logic                    reset_i,
  input  logic [pPHASE_WIDTH-1:0] I_target_phase,
  input  logic                    I_go,
  input  logic                    I_clear_errors,
  input  logic                    trigger_clk_locked,
  input  logic                    trigger_clk_psdone,
  output logic                    trigger_clk_psen,
  output logic                    trigger_clk_psincdec,
  output logic [pPHASE_WIDTH-1:0] O_current_phase,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_timeout_error,
  output logic                    O_unlock_seen
);
  localparam int CW = $clog2(pTIMEOUT + 1);
  localparam logic signed [pPHASE_WIDTH-1:0] PMAX = {1'b0, {(pPHASE_WIDTH-1){1'b1}}};
  localparam logic signed [pPHASE_WIDTH-1:0] PMIN = {1'b1, {(pPHASE_WIDTH-1){1'b0}}};
  localparam logic signed [pPHASE_WIDTH-1:0] ONE  = {{(pPHASE_WIDTH-1){1'b0}}, 1'b1};
  state_t state, state_nx;
  logic signed [pPHASE_WIDTH-1:0] tgt, cur, tgt_nx, cur_nx, go_tgt;
  logic [CW-1:0] cnt;
  logic lock_s, lost, done_nx, tmo_nx;
  trigger_clk_phase_ctrl_sync u_lock_sync (
    .clk(usb_clk),
    .rst(reset_i),
    .d  (trigger_clk_locked),
    .q  (lock_s)
  );
  assign go_tgt          = $signed(I_target_phase) == PMIN ? PMIN + ONE : $signed(I_target_phase);
  assign lost            = !lock_s && state != WAIT_LOCK;
  assign O_current_phase = cur;
  assign O_busy          = !(state inside {IDLE, ERROR, WAIT_LOCK}) || tgt != cur;
  always_comb begin
    tgt_nx   = I_go ? go_tgt : tgt;
    cur_nx   = cur;
    state_nx = state;
    done_nx  = 1'b0;
    tmo_nx   = 1'b0;
    if (lost) begin
      state_nx = WAIT_LOCK;
      cur_nx   = '0;
    end else begin
      case (state)
        WAIT_LOCK: state_nx = lock_s ? IDLE : WAIT_LOCK;
        IDLE: begin
          state_nx = tgt != cur ? STEP : IDLE;
          done_nx  = tgt == cur && I_go && go_tgt == cur;
        end
        STEP: state_nx = WAIT_DONE;
        WAIT_DONE:
          if (trigger_clk_psdone) begin
            cur_nx   = trigger_clk_psincdec ? (cur == PMAX ? cur : cur + ONE)
                                            : (cur == PMIN ? cur : cur - ONE);
            done_nx  = cur_nx == tgt;
            state_nx = done_nx ? IDLE : STEP;
          end else if (cnt == '0) begin
            tmo_nx   = 1'b1;
            state_nx = ERROR;
          end
        ERROR:   state_nx = I_clear_errors || I_go ? IDLE : ERROR;
        default: state_nx = WAIT_LOCK;
      endcase
    end
  end
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state                <= WAIT_LOCK;
      tgt                  <= '0;
      cur                  <= '0;
      cnt                  <= '0;
      trigger_clk_psen     <= 1'b0;
      trigger_clk_psincdec <= 1'b0;
      O_done               <= 1'b0;
      O_timeout_error      <= 1'b0;
      O_unlock_seen        <= 1'b0;
    end else begin
      state            <= state_nx;
      tgt              <= tgt_nx;
      cur              <= cur_nx;
      cnt              <= state == STEP ? CW'(pTIMEOUT) :
                          state == WAIT_DONE && cnt != '0 ? cnt - 1'b1 : cnt;
      trigger_clk_psen <= state_nx == STEP;
      if (state_nx == STEP) trigger_clk_psincdec <= tgt > cur_nx;
      O_done           <= done_nx;
      O_timeout_error  <= tmo_nx || (O_timeout_error && !I_clear_errors);
      O_unlock_seen    <= lost || (O_unlock_seen && !I_clear_errors);
    end
  end
endmodule

// File: tb/tb_trigger_clk_phase_ctrl.sv
// tb_trigger_clk_phase_ctrl: randomized scoreboard bench for the trigger-clock phase sequencer
module tb_trigger_clk_phase_ctrl;
  localparam int W   = 8;
  localparam int TMO = 40;
  logic clk = 1'b0, reset_i = 1'b1, I_go = 1'b0, I_clear_errors = 1'b0, lock = 1'b0;
  logic psdone_rsp = 1'b0, psdone_stim = 1'b0, psdone;
  logic [W-1:0] I_target_phase = '0, O_current_phase;
  logic psen, psincdec, O_busy, O_done, O_timeout_error, O_unlock_seen;
  int checks = 0, failures = 0;
  bit exp_dir[$];
  int exp_done[$];
  int m_pos = 0, m_tgt = 0, psen_cnt = 0, lat_lo = 1, lat_hi = 14;
  bit withhold = 1'b0, last_dir = 1'b0;
  assign psdone = psdone_rsp | psdone_stim;
  always #5 clk = ~clk;
  trigger_clk_phase_ctrl #(.pPHASE_WIDTH(W), .pTIMEOUT(TMO)) dut (
    .usb_clk(clk), .reset_i(reset_i), .I_target_phase(I_target_phase), .I_go(I_go),
    .I_clear_errors(I_clear_errors), .trigger_clk_locked(lock), .trigger_clk_psdone(psdone),
    .trigger_clk_psen(psen), .trigger_clk_psincdec(psincdec), .O_current_phase(O_current_phase),
    .O_busy(O_busy), .O_done(O_done), .O_timeout_error(O_timeout_error), .O_unlock_seen(O_unlock_seen)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic plan(input int f, input int t);
    while (f != t) begin
      exp_dir.push_back(t > f);
      f += (t > f) ? 1 : -1;
    end
    exp_done.push_back(t);
  endtask
  task automatic go(input int t, input int from);
    int ct;
    ct = (t == -(1 << (W - 1))) ? t + 1 : t;
    exp_dir.delete();
    exp_done.delete();
    plan(from, ct);
    m_tgt = ct;
    @(posedge clk); #1;
    I_target_phase = t[W-1:0];
    I_go = 1'b1;
    @(posedge clk); #1;
    I_go = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (exp_done.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, exp_done.size(), 0);
    @(negedge clk);
    chk({name, "_phase"}, $signed(O_current_phase), m_tgt);
    chk({name, "_busy"}, O_busy, 0);
    chk({name, "_steps_left"}, exp_dir.size(), 0);
  endtask
  task automatic wait_psen(input int target_cnt);
    int n = 0;
    while (psen_cnt < target_cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("psen_arrived", psen_cnt, target_cnt);
  endtask
  initial forever begin
    @(negedge clk);
    if (psen) begin
      psen_cnt++;
      last_dir = psincdec;
      if (exp_dir.size() == 0) chk("psen_unexpected", 1, 0);
      else chk("psincdec", psincdec, exp_dir.pop_front());
    end
    if (O_done) begin
      chk("done_vs_psen", psen, 0);
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_phase", $signed(O_current_phase), exp_done.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (psen && !withhold) begin
      int lat;
      bit d;
      lat = $urandom_range(lat_hi, lat_lo);
      d = psincdec;
      repeat (lat) @(posedge clk);
      #1 psdone_rsp = 1'b1;
      m_pos += d ? 1 : -1;
      @(posedge clk);
      #1 psdone_rsp = 1'b0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, pc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psen", psen, 0);
    chk("rst_psincdec", psincdec, 0);
    chk("rst_phase", O_current_phase, 0);
    chk("rst_flags", {O_busy, O_done, O_timeout_error, O_unlock_seen}, 0);
    #1 reset_i = 1'b0;
    lock = 1'b1;
    repeat (5) @(posedge clk);
    go(5, m_pos);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!psen && n < 10);
    chk("go_to_psen_latency", n, 2);
    wait_done("pos5");
    for (int i = 0; i < 6; i++) begin
      go(int'($urandom_range(40)) - 20, m_pos);
      wait_done("random");
    end
    go(m_pos, m_pos);
    wait_done("same_target");
    go(5, m_pos);
    wait_done("back5");
    pc = psen_cnt;
    go(-3, m_pos);
    wait_done("neg3");
    chk("neg3_steps", psen_cnt - pc, 8);
    go(0, m_pos);
    wait_done("zero");
    lat_lo = 12;
    lat_hi = 12;
    pc = psen_cnt;
    go(10, m_pos);
    wait_psen(pc + 4);
    repeat (2) @(negedge clk);
    pc = psen_cnt;
    go(2, m_pos + (last_dir ? 1 : -1));
    wait_done("retarget");
    chk("retarget_steps", psen_cnt - pc, 2);
    lat_lo = 1;
    lat_hi = 14;
    pc = psen_cnt;
    withhold = 1'b1;
    go(5, m_pos);
    wait_psen(pc + 1);
    n = 0;
    while (!O_timeout_error && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_window", int'(n >= TMO && n <= TMO + 3), 1);
    repeat (30) @(negedge clk);
    chk("no_psen_in_error", psen_cnt, pc + 1);
    chk("error_phase_kept", $signed(O_current_phase), m_pos);
    exp_dir.delete();
    exp_done.delete();
    plan(m_pos, 5);
    withhold = 1'b0;
    @(posedge clk); #1 I_clear_errors = 1'b1;
    @(posedge clk); #1 I_clear_errors = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", O_timeout_error, 0);
    wait_done("after_timeout");
    go(0, m_pos);
    wait_done("zero2");
    pc = psen_cnt;
    go(6, m_pos);
    n = 0;
    while (m_pos != 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    withhold = 1'b1;
    wait_psen(pc + 4);
    repeat (3) @(negedge clk);
    lock = 1'b0;
    repeat (6) @(negedge clk);
    chk("unlock_seen", O_unlock_seen, 1);
    chk("unlock_phase_zero", $signed(O_current_phase), 0);
    chk("unlock_busy", O_busy, 1);
    chk("unlock_no_psen", psen_cnt, pc + 4);
    exp_dir.delete();
    exp_done.delete();
    m_pos = 0;
    plan(0, 6);
    withhold = 1'b0;
    pc = psen_cnt;
    lock = 1'b1;
    wait_done("relock");
    chk("relock_steps", psen_cnt - pc, 6);
    @(posedge clk); #1 I_clear_errors = 1'b1;
    @(posedge clk); #1 I_clear_errors = 1'b0;
    @(negedge clk);
    chk("unlock_cleared", O_unlock_seen, 0);
    lat_lo = 1;
    lat_hi = 3;
    go(-(1 << (W - 1)), m_pos);
    wait_done("clamp_min");
    pc = psen_cnt;
    @(posedge clk); #1 psdone_stim = 1'b1;
    @(posedge clk); #1 psdone_stim = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_psdone_phase", $signed(O_current_phase), -(1 << (W - 1)) + 1);
    chk("idle_psdone_no_psen", psen_cnt, pc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trigger_clk_phase_ctrl.md
# trigger_clk_phase_ctrl

Sequences dynamic phase shifting of the trigger-clock MMCM, which generates trigger_clk from fe_clk and runs its phase-shift port on the USB clock. It accepts a signed target phase, in MMCM fine-phase steps, from the trace register block. It then issues single-step PSEN/PSINCDEC requests, waits for each PSDONE, and tracks the applied phase. It also detects lost lock and PSDONE timeouts, and reports both to the register block.

## Interface
Parameters:
- pPHASE_WIDTH, 16, signed width of target and current phase (steps).
- pTIMEOUT, 255, usb_clk cycles to wait for PSDONE before flagging an error; must be ≥ 16.

Ports:
- usb_clk  in  1  PSCLK domain. Single clock.
- reset_i  in  1  synchronous, active-high reset.
- I_target_phase  in  pPHASE_WIDTH  signed requested phase; sampled only on I_go.
- I_go  in  1  one-cycle pulse; latches I_target_phase and starts or retargets sequencing.
- I_clear_errors  in  1  clears O_timeout_error and O_unlock_seen.
- trigger_clk_locked  in  1  MMCM LOCKED (asynchronous; 2-flop synchronized internally).
- trigger_clk_psdone  in  1  MMCM PSDONE, already in usb_clk domain.
- trigger_clk_psen  out  1  one-cycle phase-step request.
- trigger_clk_psincdec  out  1  step direction: 1 = increment, 0 = decrement.
- O_current_phase  out  pPHASE_WIDTH  signed phase actually applied.
- O_busy  out  1  high whenever current phase differs from target, or a step is outstanding.
- O_done  out  1  one-cycle pulse when current phase reaches target.
- O_timeout_error  out  1  sticky: PSDONE not seen within pTIMEOUT.
- O_unlock_seen  out  1  sticky: synchronized lock dropped while out of reset.

## Operation
- States: WAIT_LOCK, IDLE, STEP, WAIT_DONE, ERROR.
- Reset:
  - State enters WAIT_LOCK.
  - Target and current phase are 0.
  - All outputs are 0.
- WAIT_LOCK → IDLE when the synchronized lock is 1.
- IDLE:
  - If target ≠ current, go to STEP.
  - Otherwise stay; O_busy = 0.
- STEP:
  - Assert psen for exactly one cycle.
  - Set psincdec = (target > current), using a signed compare.
  - Load the timeout counter with pTIMEOUT.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On psdone: current ± 1 in the direction issued.
  - Then, if the new current = target, pulse O_done and go to IDLE. Otherwise go to STEP.
  - If the counter reaches 0 without psdone: set O_timeout_error and go to ERROR. Current phase is not changed.
- ERROR:
  - No psen is issued.
  - Exit to IDLE on I_clear_errors or I_go. I_go also latches the new target.
- I_go in any state overwrites the target register. An outstanding step always completes, and the next STEP decision uses the new target. Retargeting to the current value while idle gives an O_done pulse on the following cycle.
- Lock loss (synchronized lock = 0) in any state other than WAIT_LOCK:
  - Set O_unlock_seen and go to WAIT_LOCK.
  - Force current phase to 0, because an MMCM reset discards its phase shift.
  - Keep the target, so sequencing resumes toward it after relock.
  - Lock loss has priority over psdone in the same cycle.
- Arithmetic:
  - Compares are signed at pPHASE_WIDTH.
  - A target is never reached by wrapping. Current phase saturates at the signed min/max.
  - Targets equal to the signed min are clamped to min+1, so the range stays symmetric.
- A psdone arriving outside WAIT_DONE is ignored.

## Timing
- I_go in cycle N → target register updated at N+1. From IDLE, psen is asserted at N+2.
- psen and psincdec are registered outputs. psincdec is held stable from the psen cycle until psdone.
- Step period = 1 (STEP) + PSDONE latency (typically 12 usb_clk cycles) + 1 cycle.
- O_done rises the cycle after the final psdone and is never asserted in the same cycle as psen.
- O_busy: combinational from registered state (state ≠ IDLE/ERROR/WAIT_LOCK, or target ≠ current). It is registered-equivalent: no glitch paths to the register block.
- Synchronizer latency for lock: 2 cycles.
- Minimum spacing between psen pulses is 2 cycles.

## Structure
- State encodings, the default pTIMEOUT and the register bit positions for the status flags belong in defines_trace.v, shared with trace_top.
- Single module. The only sub-module is the existing 2-flop synchronizer cell, used for trigger_clk_locked. No other hierarchy.
- Instantiated inside trace_top. It replaces direct register-driven psen/psincdec.

## Test plan
- Positive target: reset, lock=1, I_go with target +5, psdone 12 cycles after each psen → exactly 5 psen pulses with psincdec=1, then O_current_phase=5 and one O_done pulse.
- Negative target: from +5, I_go −3 → 8 psen pulses with psincdec=0, then current=−3 and O_done once.
- Retarget mid-step: target +10, I_go +2 issued while the 4th step is in WAIT_DONE → the 4th step completes, then 2 decrement steps follow; final current=2.
- Timeout: withhold psdone after the first psen → O_timeout_error set after 255 cycles and no further psen. I_clear_errors → IDLE; sequencing resumes with psdone returned → current reaches target.
- Lock loss: drop lock at current=+3 with target +6 → O_unlock_seen=1 and current=0. On relock, 6 increment steps follow.
- Saturation/clamp: target = signed min → sequencing stops at min+1. psdone during IDLE has no effect.
